// File: rtl/mem_responder_pkg.sv
// Shared definitions for the SRAM memory responder.
// Request codes driven by the CPU controller, responder FSM state encoding,
// the transaction counter width, and small mode-classification helpers.
package mem_responder_pkg;

  typedef enum logic [3:0] {
    IO_NOP = 4'h0,
    IO_LW  = 4'h1,
    IO_LB  = 4'h2,
    IO_SW  = 4'h3,
    IO_SB  = 4'h4
  } io_mode_e;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_SETUP,
    MS_ACCESS,
    MS_DONE
  } ms_state_e;

  // Wide enough for WAIT_CYCLES-1 with WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Any code outside the defined set is treated as no request.
  function automatic io_mode_e decode_mode(input logic [3:0] code);
    case (code)
      IO_LW:   return IO_LW;
      IO_LB:   return IO_LB;
      IO_SW:   return IO_SW;
      IO_SB:   return IO_SB;
      default: return IO_NOP;
    endcase
  endfunction

  function automatic logic is_read(input io_mode_e m);
    return (m == IO_LW) || (m == IO_LB);
  endfunction

  function automatic logic is_write(input io_mode_e m);
    return (m == IO_SW) || (m == IO_SB);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side request/response bus of the memory responder.
//   mem_mode : request code (mem_responder_pkg::io_mode_e values)
//   addr     : byte address          wdata    : store data
//   rdata    : load result           ready    : one-cycle completion pulse
//   addr_err : misaligned word access, pulses with ready
// master = CPU controller/datapath, slave = mem_responder.
interface mem_responder_if;
  logic [3:0]  mem_mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        addr_err;

  modport master (
    output mem_mode, addr, wdata,
    input  rdata, ready, addr_err
  );

  modport slave (
    input  mem_mode, addr, wdata,
    output rdata, ready, addr_err
  );
endinterface

// File: rtl/mem_responder_byte_lane_unit.sv
// Combinational byte-lane steering for a 32-bit little-endian SRAM.
//   mode      : decoded request         addr_lo   : byte offset addr[1:0]
//   wdata     : CPU store data          dq_i      : SRAM read data
//   be_n      : active-low byte enables dq_o      : steered store data
//   load_data : load result (LB sign-extended)
//   misalign  : word access with nonzero byte offset
module byte_lane_unit
  import mem_responder_pkg::*;
(
  input  io_mode_e    mode,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] dq_i,
  output logic [3:0]  be_n,
  output logic [31:0] dq_o,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [7:0] lane_byte;

  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    lane_byte = dq_i[{addr_lo, 3'b000} +: 8];
    be_n      = 4'hF;
    dq_o      = wdata;
    load_data = dq_i;
    misalign  = 1'b0;
    case (mode)
      IO_LW, IO_SW: begin
        // A misaligned word access still uses the aligned word.
        be_n     = 4'h0;
        misalign = (addr_lo != 2'd0);
      end
      IO_LB: begin
        be_n      = 4'h0;
        load_data = {{24{lane_byte[7]}}, lane_byte};
      end
      IO_SB: begin
        be_n = 4'hF ^ (4'b0001 << addr_lo);
        dq_o = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: turns CPU load/store requests into timed accesses
// on an external 32-bit asynchronous SRAM.  One transaction runs
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE, with ready pulsed in
// DONE.  All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : CPU request/response (mem_responder_if.slave)
//   sram_*     : SRAM address, data out/in, bus output enable, and
//                active-low chip/output/write/byte enables
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int SRAM_AW     = 20,
  parameter int WAIT_CYCLES = 2   // legal range 1..15
) (
  input  logic               clk,
  input  logic               rst_n,
  mem_responder_if.slave     bus,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [31:0]        sram_dq_i,
  output logic [31:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [3:0]         sram_be_n
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  ms_state_e           state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  io_mode_e            mode_q, mode_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                addr_err_q, addr_err_d;
  logic [SRAM_AW-1:0]  sram_addr_q, sram_addr_d;
  logic [31:0]         dq_o_q, dq_o_d;
  logic                dq_oe_q, dq_oe_d;
  logic                ce_n_q, ce_n_d;
  logic                oe_n_q, oe_n_d;
  logic                we_n_q, we_n_d;
  logic [3:0]          be_n_q, be_n_d;

  io_mode_e    req_mode;
  io_mode_e    lane_mode;
  logic [1:0]  lane_addr;
  logic [3:0]  lane_be_n;
  logic [31:0] lane_dq_o;
  logic [31:0] lane_load;
  logic        lane_misalign;
  logic        wr_ok;

  // Address bits above the SRAM window are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^bus.addr;

  assign req_mode = decode_mode(bus.mem_mode);

  // In IDLE the lane unit looks at the live request (to register the
  // SETUP-cycle outputs); afterwards it looks at the latched request, so
  // requester changes after the IDLE sample have no effect.
  assign lane_mode = (state_q == MS_IDLE) ? req_mode : mode_q;
  assign lane_addr = (state_q == MS_IDLE) ? bus.addr[1:0] : addr_lo_q;

  // Misaligned word stores never touch the SRAM.
  assign wr_ok = is_write(lane_mode) && !lane_misalign;

  byte_lane_unit u_byte_lane (
    .mode      (lane_mode),
    .addr_lo   (lane_addr),
    .wdata     (bus.wdata),
    .dq_i      (sram_dq_i),
    .be_n      (lane_be_n),
    .dq_o      (lane_dq_o),
    .load_data (lane_load),
    .misalign  (lane_misalign)
  );

  // Outputs are registered, so each branch computes the values the pins
  // take in the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    addr_lo_d   = addr_lo_q;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    addr_err_d  = 1'b0;
    sram_addr_d = sram_addr_q;
    dq_o_d      = dq_o_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    be_n_d      = be_n_q;
    case (state_q)
      MS_IDLE: begin
        if (req_mode != IO_NOP) begin
          state_d     = MS_SETUP;
          mode_d      = req_mode;
          addr_lo_d   = bus.addr[1:0];
          sram_addr_d = bus.addr[SRAM_AW+1:2];
          dq_o_d      = lane_dq_o;
          be_n_d      = lane_be_n;
          ce_n_d      = 1'b0;
          oe_n_d      = !is_read(req_mode);
          dq_oe_d     = wr_ok;
        end
      end
      MS_SETUP: begin
        state_d = MS_ACCESS;
        cnt_d   = CNT_LOAD;
        we_n_d  = !wr_ok;
      end
      MS_ACCESS: begin
        if (cnt_q == '0) begin
          state_d    = MS_DONE;
          ready_d    = 1'b1;
          addr_err_d = lane_misalign;
          we_n_d     = 1'b1;
          oe_n_d     = 1'b1;
          if (is_read(mode_q)) rdata_d = lane_load;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      MS_DONE: begin
        // Address and data were held through DONE for write hold time.
        state_d = MS_IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = 4'hF;
        dq_oe_d = 1'b0;
      end
      default: state_d = MS_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples its _d value from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MS_IDLE;
      cnt_q       <= '0;
      mode_q      <= IO_NOP;
      addr_lo_q   <= 2'd0;
      rdata_q     <= '0;
      ready_q     <= 1'b0;
      addr_err_q  <= 1'b0;
      sram_addr_q <= '0;
      dq_o_q      <= '0;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      be_n_q      <= 4'hF;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      addr_lo_q   <= addr_lo_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      addr_err_q  <= addr_err_d;
      sram_addr_q <= sram_addr_d;
      dq_o_q      <= dq_o_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      be_n_q      <= be_n_d;
    end
  end

  assign bus.rdata    = rdata_q;
  assign bus.ready    = ready_q;
  assign bus.addr_err = addr_err_q;
  assign sram_addr    = sram_addr_q;
  assign sram_dq_o    = dq_o_q;
  assign sram_dq_oe   = dq_oe_q;
  assign sram_ce_n    = ce_n_q;
  assign sram_oe_n    = oe_n_q;
  assign sram_we_n    = we_n_q;
  assign sram_be_n    = be_n_q;

endmodule
